// File: rtl/board_move_engine.sv
// Applies one 2048 slide-and-merge move to a packed 4x4 board.
// Processes one source tile per cycle, so every move takes a fixed 20 cycles.
module board_move_engine #(
   parameter int TILE_W  = 4,
   parameter int SCORE_W = 20
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            dir,
   input  logic [16*TILE_W-1:0]  board_in,
   output logic                  busy,
   output logic                  done,
   output logic [16*TILE_W-1:0]  board_out,
   output logic                  moved,
   output logic [SCORE_W-1:0]    score_delta
);

   localparam logic [TILE_W-1:0]  TILE_MAX  = '1;
   localparam logic [TILE_W-1:0]  TILE_ONE  = TILE_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

   state_t                      state_reg, state_next;
   logic [15:0][TILE_W-1:0]     src_reg;
   logic [15:0][TILE_W-1:0]     dst_reg, dst_next;
   logic [1:0]                  dir_reg;
   logic [1:0]                  line_reg, line_next;
   logic [1:0]                  pos_reg, pos_next;
   logic [2:0]                  w_reg, w_next;
   logic [TILE_W-1:0]           pend_reg, pend_next;
   logic [SCORE_W-1:0]          score_reg, score_next;
   logic [3:0]                  src_idx, dst_idx;
   logic [TILE_W-1:0]           tile;
   logic [TILE_W:0]             merge_shift;
   logic                        accept, finish;

   // Position 0 is the cell nearest the side the tiles slide towards.
   function automatic logic [3:0] cell_idx(input logic [1:0] d, input logic [1:0] line,
                                           input logic [1:0] pos);
      logic [1:0] p;
      p = d[0] ? (2'd3 - pos) : pos;
      return d[1] ? {p, line} : {line, p};
   endfunction

   assign src_idx     = cell_idx(dir_reg, line_reg, pos_reg);
   assign dst_idx     = cell_idx(dir_reg, line_reg, w_reg[1:0]);
   assign tile        = src_reg[src_idx];
   assign merge_shift = {1'b0, tile} + {{TILE_W{1'b0}}, 1'b1};
   assign accept      = (state_reg == S_IDLE) && start;
   assign busy        = (state_reg != S_IDLE);

   always_comb begin
      state_next = state_reg;
      dst_next   = dst_reg;
      line_next  = line_reg;
      pos_next   = pos_reg;
      w_next     = w_reg;
      pend_next  = pend_reg;
      score_next = score_reg;
      finish     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_SCAN;
               dst_next   = '0;
               line_next  = 2'd0;
               pos_next   = 2'd0;
               w_next     = 3'd0;
               pend_next  = '0;
               score_next = '0;
            end
         end
         S_SCAN: begin
            pos_next = pos_reg + 2'd1;
            if (pos_reg == 2'd3)
               state_next = S_FLUSH;
            if (tile != '0) begin
               if (pend_reg == '0) begin
                  pend_next = tile;
               end else if (pend_reg == tile && tile != TILE_MAX) begin
                  // Merged result goes straight out, so it can never merge again.
                  dst_next[dst_idx] = tile + TILE_ONE;
                  w_next            = w_reg + 3'd1;
                  pend_next         = '0;
                  score_next        = score_reg + (SCORE_ONE << merge_shift);
               end else begin
                  dst_next[dst_idx] = pend_reg;
                  w_next            = w_reg + 3'd1;
                  pend_next         = tile;
               end
            end
         end
         S_FLUSH: begin
            // Cells past w were cleared at accept and simply stay zero.
            if (pend_reg != '0)
               dst_next[dst_idx] = pend_reg;
            pend_next = '0;
            w_next    = 3'd0;
            pos_next  = 2'd0;
            line_next = line_reg + 2'd1;
            if (line_reg == 2'd3) begin
               state_next = S_IDLE;
               finish     = 1'b1;
            end else begin
               state_next = S_SCAN;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         src_reg     <= '0;
         dst_reg     <= '0;
         dir_reg     <= 2'd0;
         line_reg    <= 2'd0;
         pos_reg     <= 2'd0;
         w_reg       <= 3'd0;
         pend_reg    <= '0;
         score_reg   <= '0;
         done        <= 1'b0;
         board_out   <= '0;
         moved       <= 1'b0;
         score_delta <= '0;
      end else begin
         state_reg <= state_next;
         dst_reg   <= dst_next;
         line_reg  <= line_next;
         pos_reg   <= pos_next;
         w_reg     <= w_next;
         pend_reg  <= pend_next;
         score_reg <= score_next;
         done      <= finish;
         if (accept) begin
            src_reg <= board_in;
            dir_reg <= dir;
         end
         if (finish) begin
            board_out   <= dst_next;
            moved       <= (dst_next != src_reg);
            score_delta <= score_next;
         end
      end
   end

endmodule
